bnn_conv_kxk_acc: RTL and testbench

BNN_CONV_KXK_ACC -- requirements
Module: bnn_conv_kxk_acc

---
 rtl/bnn_pkg.sv | 32 +++
 rtl/bnn_xnor_popsum.sv | 123 ++++++++++++
 rtl/bnn_conv_kxk_acc.sv | 132 +++++++++++++
 tb/tb_bnn_conv_kxk_acc.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binary-weight KxK convolution accumulator:
//   - default parameter values used by the top and the pop-sum stage
//   - ch_tag_t: first/last-channel flags carried alongside each window
//   - tree_depth(): number of adder levels needed to reduce n terms
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_K          = 5;
  localparam int DEF_C_IN       = 4;
  localparam int DEF_ACC_WIDTH  = 32;

  // Position of a window inside its channel group. A window may be both
  // first and last (single-channel configuration).
  typedef struct packed {
    logic first;
    logic last;
  } ch_tag_t;

  // ceil(log2(n)) with tree_depth(1) == 0, so a single term needs no adders.
  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    while ((1 << d) < n) begin
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bnn_xnor_popsum.sv
// -----------------------------------------------------------------------------
// bnn_xnor_popsum
// First two pipeline stages of the convolution accumulator.
//   S1: per-pixel signed term (+x for weight 1, -x for weight 0), registered.
//   S2: balanced adder tree over the K*K terms, result registered as a signed
//       ACC_WIDTH partial sum (wraps modulo 2^ACC_WIDTH).
// Every register only moves when en is high, so a downstream stall freezes
// both stages together with their valid bits and channel tags.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   en            : stage enable (low = hold everything)
//   in_valid      : a window is entering S1 this cycle
//   in_tag        : first/last-channel flags of that window
//   in_data       : K*K unsigned pixels, pixel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_weight     : K*K binary weights, bit i belongs to pixel i
//   out_valid     : S2 holds a valid partial sum
//   out_tag       : flags of the window held in S2
//   out_sum       : signed window partial sum
// -----------------------------------------------------------------------------
module bnn_xnor_popsum
  import bnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  ch_tag_t                      in_tag,
  input  logic [K*K*DATA_WIDTH-1:0]    in_data,
  input  logic [K*K-1:0]               in_weight,
  output logic                         out_valid,
  output ch_tag_t                      out_tag,
  output logic signed [ACC_WIDTH-1:0]  out_sum
);

  localparam int N  = K * K;
  localparam int TW = DATA_WIDTH + 1;     // one extra bit holds the sign
  localparam int D  = tree_depth(N);
  localparam int NP = 1 << D;             // tree width padded to a power of two

  logic signed [TW-1:0]        pix;
  logic signed [TW-1:0]        term_d [N];
  logic signed [TW-1:0]        term_q [N];
  logic                        s1_valid;
  ch_tag_t                     s1_tag;
  logic signed [ACC_WIDTH-1:0] tree [D+1][NP];

  // ---------------------------------------------------------------------------
  // S1: signed terms
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb block gets a default before
  // any conditional or looped assignment, so no path can leave it unassigned
  // and infer a latch.
  always_comb begin
    pix = '0;
    for (int i = 0; i < N; i++) begin
      pix       = TW'({1'b0, in_data[i*DATA_WIDTH +: DATA_WIDTH]});
      term_d[i] = in_weight[i] ? pix : -pix;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits decide whether their
  // contents mean anything, which keeps reset fan-out to the control path.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < N; i++) begin
        term_q[i] <= term_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree between S1 and S2. Level 0 holds the sign-extended terms, padded
  // with zeros; each level halves the number of operands.
  // ---------------------------------------------------------------------------
  always_comb begin
    tree = '{default: '0};
    for (int i = 0; i < N; i++) begin
      tree[0][i] = ACC_WIDTH'(term_q[i]);
    end
    for (int d = 1; d <= D; d++) begin
      for (int i = 0; i < (NP >> d); i++) begin
        tree[d][i] = tree[d-1][2*i] + tree[d-1][2*i+1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: registered partial sum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_tag   <= s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      out_sum <= tree[D][0];
    end
  end

endmodule

// File: rtl/bnn_conv_kxk_acc.sv
// -----------------------------------------------------------------------------
// bnn_conv_kxk_acc
// Binary-weight KxK convolution with channel accumulation. Each accepted beat
// carries one input channel's KxK window; C_IN consecutive beats form one
// output. Three stages: S1 signed terms, S2 window partial sum, S3 channel
// accumulation plus the registered result and its binarised bit.
// Latency: a beat presented in the cycle after edge t (accepted at edge t+1)
// that completes a group shows m_valid after edge t+3.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   s_valid    : input window valid
//   s_ready    : window accepted this cycle (combinational, 0 during reset)
//   s_data     : K*K unsigned pixels, pixel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_weight   : K*K binary weights, bit i for pixel i (1 = +x, 0 = -x)
//   threshold  : signed binarisation threshold, sampled when a result loads
//   m_valid    : result valid
//   m_ready    : downstream accepts the result
//   m_data     : signed channel-summed result (wraps modulo 2^ACC_WIDTH)
//   m_bit      : m_data >= threshold (signed)
// -----------------------------------------------------------------------------
module bnn_conv_kxk_acc
  import bnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int C_IN       = DEF_C_IN,     // legal range 1..256
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [K*K*DATA_WIDTH-1:0]    s_data,
  input  logic [K*K-1:0]               s_weight,
  input  logic signed [ACC_WIDTH-1:0]  threshold,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [ACC_WIDTH-1:0]  m_data,
  output logic                         m_bit
);

  // A single-channel build still gets a 1-bit counter that never leaves 0.
  localparam int             CW      = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic [CW-1:0]  LAST_CH = CW'(C_IN - 1);

  logic                        stall;
  logic                        accept;
  logic [CW-1:0]               ch_cnt;
  ch_tag_t                     in_tag;
  logic                        s2_valid;
  ch_tag_t                     s2_tag;
  logic signed [ACC_WIDTH-1:0] s2_sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] final_sum;
  logic                        load_result;

  // ---------------------------------------------------------------------------
  // Handshake. A result that downstream refuses freezes the whole pipe; the
  // input side is told immediately so no beat is accepted into a frozen S1.
  // ---------------------------------------------------------------------------
  assign stall   = m_valid && !m_ready;
  assign s_ready = !stall && !rst;
  assign accept  = s_valid && s_ready;

  // ---------------------------------------------------------------------------
  // Channel counter: advances on accepted beats only, so bubbles never shift
  // the channel assignment of later beats.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_tag       = '0;
    in_tag.first = (ch_cnt == '0);
    in_tag.last  = (ch_cnt == LAST_CH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= in_tag.last ? '0 : ch_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // S1 / S2
  // ---------------------------------------------------------------------------
  bnn_xnor_popsum #(
    .DATA_WIDTH (DATA_WIDTH),
    .K          (K),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_popsum (
    .clk        (clk),
    .rst        (rst),
    .en         (!stall),
    .in_valid   (accept),
    .in_tag     (in_tag),
    .in_data    (s_data),
    .in_weight  (s_weight),
    .out_valid  (s2_valid),
    .out_tag    (s2_tag),
    .out_sum    (s2_sum)
  );

  // ---------------------------------------------------------------------------
  // S3: the first channel of a group restarts the running sum rather than
  // adding to the previous group's leftover.
  // ---------------------------------------------------------------------------
  assign final_sum   = s2_tag.first ? s2_sum : acc + s2_sum;
  assign load_result = s2_valid && s2_tag.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_bit   <= 1'b0;
    end else if (!stall) begin
      if (s2_valid) begin
        acc <= final_sum;
      end
      // Not stalled means any pending result is being taken this edge: either
      // a new result replaces it or the output goes idle.
      m_valid <= load_result;
      if (load_result) begin
        m_data <= final_sum;
        m_bit  <= (final_sum >= threshold);
      end
    end
  end

endmodule

// File: tb/tb_bnn_conv_kxk_acc.sv
// -----------------------------------------------------------------------------
// tb_bnn_conv_kxk_acc
// Directed bench for bnn_conv_kxk_acc. Two instances share the input bus:
// dut (C_IN=4) and dut1 (C_IN=1). Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge. A monitor logs every result
// handshake with its cycle number so group counts and spacing can be checked.
// -----------------------------------------------------------------------------
module tb_bnn_conv_kxk_acc;

  localparam int DW = 8;
  localparam int K  = 5;
  localparam int N  = K * K;
  localparam int AW = 32;

  logic                 clk;
  logic                 rst;
  logic [N*DW-1:0]      s_data;
  logic [N-1:0]         s_weight;
  logic signed [AW-1:0] threshold;

  logic                 s_valid, s_ready, m_valid, m_ready, m_bit;
  logic signed [AW-1:0] m_data;
  logic                 s_valid1, s_ready1, m_valid1, m_ready1, m_bit1;
  logic signed [AW-1:0] m_data1;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic signed [AW-1:0] data;
    logic                 b;
    int                   cyc;
  } res_t;

  res_t q[$];
  res_t q1[$];

  bnn_conv_kxk_acc #(.DATA_WIDTH(DW), .K(K), .C_IN(4), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_weight  (s_weight),
    .threshold (threshold),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_bit     (m_bit)
  );

  bnn_conv_kxk_acc #(.DATA_WIDTH(DW), .K(K), .C_IN(1), .ACC_WIDTH(AW)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid1),
    .s_ready   (s_ready1),
    .s_data    (s_data),
    .s_weight  (s_weight),
    .threshold (threshold),
    .m_valid   (m_valid1),
    .m_ready   (m_ready1),
    .m_data    (m_data1),
    .m_bit     (m_bit1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready)   q.push_back('{data: m_data, b: m_bit, cyc: cyc});
    if (m_valid1 && m_ready1) q1.push_back('{data: m_data1, b: m_bit1, cyc: cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus, required finish before time limit");
    $fatal(1, "time limit reached");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [7:0] v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pat(input int seed);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = 8'((i * 37 + seed * 53 + 11) % 256);
    return r;
  endfunction

  function automatic logic [N-1:0] wpat(input int n);
    logic [N-1:0] base;
    logic [N-1:0] mask;
    base = 25'h1555555;
    mask = 25'h1F;
    return base ^ (mask << n);
  endfunction

  // Reference: plain signed sum of +/- pixels.
  function automatic int win_sum(input logic [N*DW-1:0] d, input logic [N-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      if (w[i]) s = s + int'(d[i*DW +: DW]);
      else      s = s - int'(d[i*DW +: DW]);
    end
    return s;
  endfunction

  // Present one beat to dut (sel=0) or dut1 (sel=1) until it is accepted.
  task automatic send(input bit sel, input logic [N*DW-1:0] d, input logic [N-1:0] w);
    bit ok;
    ok       = 1'b0;
    s_data   = d;
    s_weight = w;
    if (sel) s_valid1 = 1'b1;
    else     s_valid  = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (sel ? s_ready1 : s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid  = 1'b0;
    s_valid1 = 1'b0;
    check("beat_accepted", ok, 1);
  endtask

  // Wait (bounded) for the next result of the selected instance.
  task automatic wait_res(input bit sel, output logic signed [AW-1:0] d, output logic b);
    bit got;
    got = 1'b0;
    d   = '0;
    b   = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (sel ? m_valid1 : m_valid) begin
        got = 1'b1;
        d   = sel ? m_data1 : m_data;
        b   = sel ? m_bit1 : m_bit;
      end
    end
    check("result_arrived", got, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic signed [AW-1:0] rd;
    logic                 rb;
    logic [N*DW-1:0]      dv;
    int                   exp_g [2];

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_valid1  = 1'b0;
    m_ready   = 1'b1;
    m_ready1  = 1'b1;
    threshold = '0;
    s_data    = '0;
    s_weight  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_bit", m_bit, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid1", m_valid1, 0);
    check("rst_s_ready1", s_ready1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // C_IN=1: all 10, all +, result 250 exactly three edges after presenting
    send(1'b1, fill(8'd10), '1);
    @(negedge clk); check("lat_edge1_m_valid", m_valid1, 0);
    @(negedge clk); check("lat_edge2_m_valid", m_valid1, 0);
    @(negedge clk);
    check("lat_edge3_m_valid", m_valid1, 1);
    check("sum250_data", m_data1, 250);
    check("sum250_bit", m_bit1, 1);
    @(negedge clk); check("taken_clears_valid", m_valid1, 0);
    @(posedge clk); #1;

    // Threshold boundary
    threshold = 250;
    send(1'b1, fill(8'd10), '1);
    wait_res(1'b1, rd, rb);
    check("thr250_data", rd, 250);
    check("thr250_bit", rb, 1);
    @(posedge clk); #1;
    threshold = 251;
    send(1'b1, fill(8'd10), '1);
    wait_res(1'b1, rd, rb);
    check("thr251_bit", rb, 0);
    @(posedge clk); #1;

    // Mixed weights: 12 at +10, 13 at -10 -> -10; threshold -10 -> bit 1
    threshold = -10;
    send(1'b1, fill(8'd10), 25'h0000FFF);
    wait_res(1'b1, rd, rb);
    check("mixed_data", rd, -10);
    check("mixed_bit", rb, 1);
    @(posedge clk); #1;

    // Pixel indexing: pixel0=200 (w0=0), pixel24=100 (w24=1) -> -100
    threshold = 0;
    dv = fill(8'd0);
    dv[7:0]     = 8'd200;
    dv[199:192] = 8'd100;
    send(1'b1, dv, 25'h1000000);
    wait_res(1'b1, rd, rb);
    check("edge_pixels_data", rd, -100);
    check("edge_pixels_bit", rb, 0);
    @(posedge clk); #1;

    // C_IN=1 full throughput: three results on consecutive cycles
    q1.delete();
    send(1'b1, fill(8'd1), '1);
    send(1'b1, fill(8'd2), '1);
    send(1'b1, fill(8'd3), '1);
    repeat (5) @(negedge clk);
    check("c1_stream_count", q1.size(), 3);
    if (q1.size() == 3) begin
      check("c1_stream_r0", q1[0].data, 25);
      check("c1_stream_r1", q1[1].data, 50);
      check("c1_stream_r2", q1[2].data, 75);
      check("c1_stream_gap01", q1[1].cyc - q1[0].cyc, 1);
      check("c1_stream_gap12", q1[2].cyc - q1[1].cyc, 1);
    end
    @(posedge clk); #1;

    // C_IN=4: 255 with all - on 4 beats -> -25500, single pulse
    q.delete();
    repeat (4) send(1'b0, fill(8'd255), '0);
    repeat (6) @(negedge clk);
    check("neg_count", q.size(), 1);
    if (q.size() == 1) begin
      check("neg_data", q[0].data, -25500);
      check("neg_bit", q[0].b, 0);
    end
    @(posedge clk); #1;

    // Stall: group A (sum 100) held while group B (sum 200) is in flight
    q.delete();
    m_ready = 1'b0;
    repeat (4) send(1'b0, fill(8'd1), '1);
    repeat (2) send(1'b0, fill(8'd2), '1);
    s_data   = fill(8'd2);
    s_weight = '1;
    s_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, 100);
      check("stall_m_bit", m_bit, 1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    repeat (2) send(1'b0, fill(8'd2), '1);
    repeat (6) @(negedge clk);
    check("stall_count", q.size(), 2);
    if (q.size() == 2) begin
      check("stall_first", q[0].data, 100);
      check("stall_second", q[1].data, 200);
    end
    @(posedge clk); #1;

    // Back-to-back groups with varied data and weights
    q.delete();
    for (int g = 0; g < 2; g++) begin
      exp_g[g] = 0;
      for (int c = 0; c < 4; c++) exp_g[g] += win_sum(pat(g * 4 + c), wpat(g * 4 + c));
    end
    for (int b = 0; b < 8; b++) send(1'b0, pat(b), wpat(b));
    repeat (6) @(negedge clk);
    check("b2b_count", q.size(), 2);
    if (q.size() == 2) begin
      check("b2b_g0_data", q[0].data, exp_g[0]);
      check("b2b_g0_bit", q[0].b, (exp_g[0] >= 0) ? 1 : 0);
      check("b2b_g1_data", q[1].data, exp_g[1]);
      check("b2b_g1_bit", q[1].b, (exp_g[1] >= 0) ? 1 : 0);
      check("b2b_spacing", q[1].cyc - q[0].cyc, 4);
    end
    @(posedge clk); #1;

    // Reset after 2 of 4 channels: partials discarded
    q.delete();
    repeat (2) send(1'b0, fill(8'd255), '1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_data", m_data, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_result", q.size(), 0);
    @(posedge clk); #1;
    repeat (4) send(1'b0, fill(8'd1), '1);
    repeat (6) @(negedge clk);
    check("postrst_count", q.size(), 1);
    if (q.size() == 1) begin
      check("postrst_data", q[0].data, 100);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
